// File: rtl/hydra_egress_rx.sv
// hydra_egress_rx: egress-side sink for one hydra read port.
// Requests packets with a one-cycle ready pulse, captures the sop/vld/eop
// framed packet, checks header dest and length, and forwards every word
// through a first-word-fall-through FIFO with first/last markers.

module hydra_egress_rx #(
  parameter int PORT_ID    = 3,
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_PKT    = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        rd_sop,
  input  logic        rd_eop,
  input  logic        rd_vld,
  input  logic [15:0] rd_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_first,
  output logic        m_last,
  output logic [15:0] pkt_cnt,
  output logic        err_len,
  output logic        err_port,
  output logic        err_timeout,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_PKT) + 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_PKT);
  localparam logic [BW-1:0] BEAT_SAT  = BW'(MAX_PKT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [AW+1:0] DEPTH_W   = (AW + 2)'(FIFO_DEPTH);
  localparam logic [AW+1:0] ADMIT_W   = (AW + 2)'(MAX_PKT);
  localparam logic [1:0]    MY_PORT   = 2'(PORT_ID);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_SOP,
    HDR,
    BODY,
    CLOSE
  } state_t;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] data;
  } entry_t;

  state_t state, state_next;

  // Request timeout counter
  logic [TW-1:0] tmo_cnt;

  // Header fields and framing bookkeeping for the packet in flight
  logic [BW-1:0] beat_cnt;
  logic [7:0]    hdr_len;
  logic [1:0]    hdr_dest;
  logic          hdr_seen;
  logic          len_err_r;
  logic [BW-1:0] exp_beats;

  // One-word holding register: the newest word waits here until we know
  // whether another word follows it or eop closes the packet.
  logic          hold_valid;
  logic          hold_first;
  logic [15:0]   hold_data;

  // Push stage between the holding register and FIFO memory
  logic          stg_valid;
  entry_t        stg;

  // FIFO storage and pointers (one extra bit to tell full from empty)
  entry_t        mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          pop;
  entry_t        head;
  logic [AW+1:0] used_words;
  logic [AW+1:0] free_words;

  // Strobes from the FSM to the datapath
  logic tmo_clr;
  logic tmo_inc;
  logic hdr_take;
  logic hdr_noword;
  logic beat_take;
  logic beat_drop;
  logic flush_last;

  // FIFO status: the push stage counts as occupied so admission never
  // over-commits storage while the final word of a packet is in transit.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    head       = mem[rd_ptr[AW-1:0]];
    pop        = !fifo_empty && m_ready;
    used_words = {1'b0, wr_ptr - rd_ptr} + {{(AW + 1){1'b0}}, stg_valid};
    free_words = DEPTH_W - used_words;
    exp_beats  = {{(BW - 8){1'b0}}, hdr_len} + BW'(1);
  end

  assign m_valid = !fifo_empty;
  assign m_data  = head.data;
  assign m_first = !fifo_empty && head.first;
  assign m_last  = !fifo_empty && head.last;
  assign busy    = (state != IDLE);

  // Next-state logic, request/error pulses and datapath strobes
  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    err_len     = 1'b0;
    err_port    = 1'b0;
    err_timeout = 1'b0;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
    hdr_take    = 1'b0;
    hdr_noword  = 1'b0;
    beat_take   = 1'b0;
    beat_drop   = 1'b0;
    flush_last  = 1'b0;
    case (state)
      IDLE: begin
        if (free_words >= ADMIT_W) begin
          state_next = REQ;
        end
      end
      REQ: begin
        ready      = 1'b1;
        tmo_clr    = 1'b1;
        state_next = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (rd_sop) begin
          state_next = HDR;
        end else if (tmo_cnt == TMO_LIMIT) begin
          err_timeout = 1'b1;
          state_next  = IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      HDR: begin
        if (rd_vld) begin
          hdr_take   = 1'b1;
          state_next = rd_eop ? CLOSE : BODY;
        end else if (rd_eop) begin
          hdr_noword = 1'b1;
          state_next = CLOSE;
        end
      end
      BODY: begin
        if (rd_vld) begin
          if (beat_cnt < BEAT_MAX) begin
            beat_take = 1'b1;
          end else begin
            beat_drop = 1'b1;
          end
        end
        if (rd_eop) begin
          state_next = CLOSE;
          flush_last = !rd_vld;
        end
      end
      CLOSE: begin
        err_len    = len_err_r || (beat_cnt != exp_beats);
        err_port   = hdr_seen && (hdr_dest != MY_PORT);
        flush_last = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cycles spent waiting for rd_sop since the last request
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (tmo_inc) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Header latch, saturating beat count and sticky length-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      hdr_len   <= '0;
      hdr_dest  <= '0;
      hdr_seen  <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      if (state == REQ) begin
        beat_cnt  <= '0;
        hdr_seen  <= 1'b0;
        len_err_r <= 1'b0;
      end
      if (hdr_take) begin
        hdr_len  <= rd_data[11:4];
        hdr_dest <= rd_data[1:0];
        hdr_seen <= 1'b1;
        beat_cnt <= BW'(1);
      end
      if ((beat_take || beat_drop) && (beat_cnt != BEAT_SAT)) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (beat_drop || hdr_noword) begin
        len_err_r <= 1'b1;
      end
    end
  end

  // Holding register and push stage: a new word pushes the held one with
  // last=0, while eop (or the close cycle) pushes it with last=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      hold_data  <= '0;
      stg_valid  <= 1'b0;
      stg        <= '0;
    end else begin
      stg_valid <= 1'b0;
      if (hdr_take) begin
        hold_valid <= 1'b1;
        hold_first <= 1'b1;
        hold_data  <= rd_data;
      end else if (beat_take) begin
        stg_valid  <= hold_valid;
        stg        <= '{first: hold_first, last: 1'b0, data: hold_data};
        hold_valid <= 1'b1;
        hold_first <= 1'b0;
        hold_data  <= rd_data;
      end else if (flush_last && hold_valid) begin
        stg_valid  <= 1'b1;
        stg        <= '{first: hold_first, last: 1'b1, data: hold_data};
        hold_valid <= 1'b0;
      end
    end
  end

  // FIFO pointers; push and pop in the same cycle are both honoured
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (stg_valid) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (!rst && stg_valid) begin
      mem[wr_ptr[AW-1:0]] <= stg;
    end
  end

  // Good-packet counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (state == CLOSE && !err_len && !err_port) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hydra_egress_rx.md
Name: hydra_egress_rx

Overview:
- Egress-side sink for one hydra read port; the opposite end of the switch's rd_* interface.
- Requests packets by pulsing ready, captures the rd_sop / rd_vld / rd_eop framed packet and checks its header and length.
- Buffers the packet in a first-word-fall-through FIFO and forwards it on a valid/ready stream with first/last markers.
- One instance per output port; sits between hydra and downstream consumer logic.

Parameters:
- PORT_ID, 3, value the dest field of every received header must match (0..3).
- FIFO_DEPTH, 512, words of packet storage; power of two and at least 2*MAX_PKT.
- MAX_PKT, 256, largest legal packet in words, header included.
- TIMEOUT, 1023, cycles to wait for rd_sop after a request before giving up.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ready  out  1  one-cycle request pulse to hydra.
- rd_sop  in  1  start-of-packet pulse.
- rd_eop  in  1  end-of-packet pulse.
- rd_vld  in  1  rd_data valid.
- rd_data  in  16  packet word; first valid word is the header.
- m_valid  out  1  downstream word available.
- m_ready  in  1  downstream accept.
- m_data  out  16  downstream word.
- m_first  out  1  m_data is a header word.
- m_last  out  1  m_data is the final word of its packet.
- pkt_cnt  out  16  count of good packets; wraps from 0xFFFF to 0.
- err_len  out  1  one-cycle pulse on a length error.
- err_port  out  1  one-cycle pulse on a dest mismatch.
- err_timeout  out  1  one-cycle pulse on a request timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Header word format:
  - [15:12] reserved, ignored.
  - [11:4] len, the number of payload words after the header (0..255).
  - [3:2] priority, passed through unchanged.
  - [1:0] dest.
- Reset: FSM to IDLE, FIFO flushed, all counters cleared. ready, m_valid, m_first, m_last, err_* and busy are 0, pkt_cnt is 0. Reset mid-packet discards the packet with no error pulse.
- FSM states: IDLE, REQ, WAIT_SOP, HDR, BODY, CLOSE.
- IDLE -> REQ when FIFO free words >= MAX_PKT.
- REQ: ready=1 for exactly one cycle, then go to WAIT_SOP and clear the timeout counter.
- WAIT_SOP:
  - On rd_sop, go to HDR.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, pulse err_timeout and go to IDLE.
- HDR:
  - The first rd_vld word is the header. Latch len and dest, set beat count to 1, go to BODY.
  - rd_eop before any rd_vld counts as a length error; go to CLOSE.
- BODY:
  - Each rd_vld increments the beat count.
  - Beats beyond MAX_PKT are dropped and force a length error.
  - rd_eop goes to CLOSE. rd_vld and rd_eop in the same cycle: the word is accepted first.
- CLOSE (one cycle):
  - Length error when beat count != len+1.
  - Port error when dest != PORT_ID.
  - err_len and err_port pulse in this cycle.
  - pkt_cnt increments only when neither error occurred.
  - Then go to IDLE.
- rd_sop, rd_vld and rd_eop are ignored in IDLE, REQ and CLOSE; rd_vld is also ignored in WAIT_SOP.
- Last-word marking uses a one-word holding register:
  - Each accepted word pushes the previously held word into the FIFO with last=0.
  - rd_eop pushes the held word with last=1.
  - first=1 is stored with the header word.
  - Packets with errors are still forwarded intact up to MAX_PKT words.
- FIFO is first-word-fall-through:
  - m_valid = !empty; m_data, m_first and m_last come from the head entry.
  - A pop happens when m_valid and m_ready are both high.
  - Push and pop in the same cycle are both honoured.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Latency: a word reaches m_data 2 cycles after the following beat, or after rd_eop for the last word. The FIFO never overflows because of the MAX_PKT admission check.

Test Plan:
1. Header {4'd0,8'd31,2'd1,2'd3}, 31 payload words 0..30, then eop, with PORT_ID=3 and m_ready=1 -> 32 m_valid beats; m_first on the header; m_last on word 30; pkt_cnt=1; no err pulses.
2. Same packet with header dest=2 -> all 32 words forwarded; err_port pulses once; pkt_cnt stays 0.
3. len=31 but only 20 payload words before eop -> err_len pulses once; m_last on the 21st word; pkt_cnt unchanged.
4. No rd_sop after ready -> err_timeout pulses exactly 1024 cycles after the ready pulse (TIMEOUT cycles of waiting); FSM returns to IDLE; a new ready pulse follows.
5. m_ready=0 while two 256-word packets arrive -> FIFO holds 512 words; no third ready pulse until at least 256 words are drained; all words are then delivered in order with none lost.
6. rst asserted during BODY at beat 10 -> next cycle m_valid=0, busy=0, pkt_cnt=0; a following clean packet is received correctly.
